// File: rtl/lbuffer.sv
// Load buffer: in-order queue of load requests, one outstanding memory read, extended CDB broadcast.
// Optional feature LBUFFER_BYPASS_EN: a push into an empty idle queue drives the memory request that same cycle.
`ifndef AddressWidth
`define AddressWidth 32
`endif
`ifndef ROBWidth
`define ROBWidth 5
`endif
`ifndef InstTypeWidth
`define InstTypeWidth 6
`endif
`ifndef IDWidth
`define IDWidth 32
`endif
`ifndef LB
`define LB  6'd10
`define LH  6'd11
`define LW  6'd12
`define LBU 6'd13
`define LHU 6'd14
`endif

module lbuffer #(
    parameter int LB_DEPTH = 8
) (
    input  logic                        clk_in,
    input  logic                        rst_in,
    input  logic                        rdy_in,
    input  logic                        addrunit_lbuffer_en_in,
    input  logic [`AddressWidth-1:0]    addrunit_lbuffer_a_in,
    input  logic [`ROBWidth-1:0]        addrunit_lbuffer_dest_in,
    input  logic [`InstTypeWidth-1:0]   addrunit_lbuffer_opcode_in,
    output logic                        lbuffer_full_out,
    input  logic                        rob_lbuffer_rst_in,
    output logic                        lbuffer_mem_en_out,
    output logic [`AddressWidth-1:0]    lbuffer_mem_a_out,
    output logic [2:0]                  lbuffer_mem_len_out,
    input  logic                        mem_lbuffer_valid_in,
    input  logic [31:0]                 mem_lbuffer_data_in,
    output logic                        lbuffer_cdb_en_out,
    output logic [`ROBWidth-1:0]        lbuffer_cdb_dest_out,
    output logic [`IDWidth-1:0]         lbuffer_cdb_value_out,
    output logic [1:0]                  lbuffer_state_dbg_out,
    output logic [$clog2(LB_DEPTH):0]   lbuffer_count_dbg_out
);

    localparam int PW = $clog2(LB_DEPTH);
    localparam logic [PW:0]   DEPTH_C = (PW+1)'(LB_DEPTH);
    localparam logic [PW:0]   CNT_INC = (PW+1)'(1);
    localparam logic [PW:0]   FULL_C  = DEPTH_C - CNT_INC;
    localparam logic [PW-1:0] PTR_INC = PW'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_BCAST = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t                      state_q, state_d;
    logic [PW-1:0]               head_q, head_d, tail_q, tail_d;
    logic [PW:0]                 count_q, count_d;
    logic                        mem_en_q, mem_en_d;
    logic [`AddressWidth-1:0]    mem_a_q, mem_a_d;
    logic [2:0]                  mem_len_q, mem_len_d;
    logic [`InstTypeWidth-1:0]   req_op_q, req_op_d;
    logic [`ROBWidth-1:0]        req_dest_q, req_dest_d;
    logic                        cdb_en_q, cdb_en_d;
    logic [`ROBWidth-1:0]        cdb_dest_q, cdb_dest_d;
    logic [`IDWidth-1:0]         cdb_value_q, cdb_value_d;

    logic [`AddressWidth-1:0]    ent_addr_q [LB_DEPTH];
    logic [`ROBWidth-1:0]        ent_dest_q [LB_DEPTH];
    logic [`InstTypeWidth-1:0]   ent_op_q   [LB_DEPTH];

    logic push_ok;
    logic pop;
    logic bypass;

    function automatic logic [2:0] len_of(input logic [`InstTypeWidth-1:0] op);
        case (op)
            `LB, `LBU: len_of = 3'd1;
            `LH, `LHU: len_of = 3'd2;
            default:   len_of = 3'd4;
        endcase
    endfunction

    function automatic logic [`IDWidth-1:0] extend(input logic [`InstTypeWidth-1:0] op,
                                                   input logic [31:0] d);
        case (op)
            `LB:     extend = {{24{d[7]}}, d[7:0]};
            `LH:     extend = {{16{d[15]}}, d[15:0]};
            `LBU:    extend = {24'b0, d[7:0]};
            `LHU:    extend = {16'b0, d[15:0]};
            default: extend = d;
        endcase
    endfunction

    // A push is never taken in the same cycle as a flush or when every slot is occupied.
    assign push_ok = rdy_in && addrunit_lbuffer_en_in && !rob_lbuffer_rst_in && (count_q < DEPTH_C);

    always_comb begin
        bypass = 1'b0;
`ifdef LBUFFER_BYPASS_EN
        bypass = push_ok && (state_q == S_IDLE) && (count_q == '0);
`endif
    end

    always_comb begin
        state_d     = state_q;
        head_d      = head_q;
        tail_d      = tail_q;
        count_d     = count_q;
        mem_en_d    = mem_en_q;
        mem_a_d     = mem_a_q;
        mem_len_d   = mem_len_q;
        req_op_d    = req_op_q;
        req_dest_d  = req_dest_q;
        cdb_en_d    = 1'b0;
        cdb_dest_d  = cdb_dest_q;
        cdb_value_d = cdb_value_q;
        pop         = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (bypass) begin
                    state_d    = S_REQ;
                    mem_en_d   = 1'b1;
                    mem_a_d    = addrunit_lbuffer_a_in;
                    mem_len_d  = len_of(addrunit_lbuffer_opcode_in);
                    req_op_d   = addrunit_lbuffer_opcode_in;
                    req_dest_d = addrunit_lbuffer_dest_in;
                end else if (count_q != '0) begin
                    state_d    = S_REQ;
                    mem_en_d   = 1'b1;
                    mem_a_d    = ent_addr_q[head_q];
                    mem_len_d  = len_of(ent_op_q[head_q]);
                    req_op_d   = ent_op_q[head_q];
                    req_dest_d = ent_dest_q[head_q];
                end
            end
            S_REQ: begin
                if (mem_lbuffer_valid_in) begin
                    pop         = 1'b1;
                    state_d     = S_BCAST;
                    mem_en_d    = 1'b0;
                    cdb_en_d    = 1'b1;
                    cdb_dest_d  = req_dest_q;
                    cdb_value_d = extend(req_op_q, mem_lbuffer_data_in);
                end
            end
            S_BCAST: state_d = S_IDLE;
            S_DRAIN: begin
                if (mem_lbuffer_valid_in) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (push_ok) tail_d = tail_q + PTR_INC;
        if (pop)     head_d = head_q + PTR_INC;
        if (push_ok && !pop)      count_d = count_q + CNT_INC;
        else if (pop && !push_ok) count_d = count_q - CNT_INC;

        // A read already handed to memory must still be consumed, so an unanswered request drains.
        if (rob_lbuffer_rst_in) begin
            head_d   = '0;
            tail_d   = '0;
            count_d  = '0;
            mem_en_d = 1'b0;
            cdb_en_d = 1'b0;
            if ((state_q == S_REQ || state_q == S_DRAIN) && !mem_lbuffer_valid_in) state_d = S_DRAIN;
            else state_d = S_IDLE;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q     <= S_IDLE;
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            mem_en_q    <= 1'b0;
            mem_a_q     <= '0;
            mem_len_q   <= '0;
            req_op_q    <= '0;
            req_dest_q  <= '0;
            cdb_en_q    <= 1'b0;
            cdb_dest_q  <= '0;
            cdb_value_q <= '0;
        end else if (rdy_in) begin
            state_q     <= state_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            mem_en_q    <= mem_en_d;
            mem_a_q     <= mem_a_d;
            mem_len_q   <= mem_len_d;
            req_op_q    <= req_op_d;
            req_dest_q  <= req_dest_d;
            cdb_en_q    <= cdb_en_d;
            cdb_dest_q  <= cdb_dest_d;
            cdb_value_q <= cdb_value_d;
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in && push_ok) begin
            ent_addr_q[tail_q] <= addrunit_lbuffer_a_in;
            ent_dest_q[tail_q] <= addrunit_lbuffer_dest_in;
            ent_op_q[tail_q]   <= addrunit_lbuffer_opcode_in;
        end
    end

    // Memory handshake: mem_en stays high with stable addr/len until the one-cycle valid pulse.
    assign lbuffer_mem_en_out    = mem_en_q | bypass;
    assign lbuffer_mem_a_out     = bypass ? addrunit_lbuffer_a_in : mem_a_q;
    assign lbuffer_mem_len_out   = bypass ? len_of(addrunit_lbuffer_opcode_in) : mem_len_q;
    assign lbuffer_full_out      = (count_q >= FULL_C);
    assign lbuffer_cdb_en_out    = cdb_en_q;
    assign lbuffer_cdb_dest_out  = cdb_dest_q;
    assign lbuffer_cdb_value_out = cdb_value_q;
    assign lbuffer_state_dbg_out = state_q;
    assign lbuffer_count_dbg_out = count_q;

endmodule

// File: tb/tb_lbuffer.sv
// Directed bench for lbuffer: extension, ordering, wrap, flush/drain, push+pop, rdy freeze.
`ifndef AddressWidth
`define AddressWidth 32
`endif
`ifndef ROBWidth
`define ROBWidth 5
`endif
`ifndef InstTypeWidth
`define InstTypeWidth 6
`endif
`ifndef IDWidth
`define IDWidth 32
`endif
`ifndef LB
`define LB  6'd10
`define LH  6'd11
`define LW  6'd12
`define LBU 6'd13
`define LHU 6'd14
`endif

module tb_lbuffer;
    localparam int LB_DEPTH = 8;

    logic                      clk = 1'b0;
    logic                      rst, rdy, push_en, flush, mem_valid;
    logic [`AddressWidth-1:0]  push_a;
    logic [`ROBWidth-1:0]      push_dest;
    logic [`InstTypeWidth-1:0] push_op;
    logic [31:0]               mem_data;
    logic                      full, mem_en, cdb_en;
    logic [`AddressWidth-1:0]  mem_a;
    logic [2:0]                mem_len;
    logic [`ROBWidth-1:0]      cdb_dest;
    logic [`IDWidth-1:0]       cdb_value;
    logic [1:0]                state_dbg;
    logic [3:0]                count_dbg;

    int n_checks = 0;
    int n_errors = 0;
    logic [36:0] exp_q[$];

    logic [`InstTypeWidth-1:0] tbl_op   [8];
    logic [31:0]               tbl_data [8];
    logic [31:0]               tbl_exp  [8];
    logic [2:0]                tbl_len  [8];

    always #5 clk = ~clk;

    lbuffer #(.LB_DEPTH(LB_DEPTH)) dut (
        .clk_in                     (clk),
        .rst_in                     (rst),
        .rdy_in                     (rdy),
        .addrunit_lbuffer_en_in     (push_en),
        .addrunit_lbuffer_a_in      (push_a),
        .addrunit_lbuffer_dest_in   (push_dest),
        .addrunit_lbuffer_opcode_in (push_op),
        .lbuffer_full_out           (full),
        .rob_lbuffer_rst_in         (flush),
        .lbuffer_mem_en_out         (mem_en),
        .lbuffer_mem_a_out          (mem_a),
        .lbuffer_mem_len_out        (mem_len),
        .mem_lbuffer_valid_in       (mem_valid),
        .mem_lbuffer_data_in        (mem_data),
        .lbuffer_cdb_en_out         (cdb_en),
        .lbuffer_cdb_dest_out       (cdb_dest),
        .lbuffer_cdb_value_out      (cdb_value),
        .lbuffer_state_dbg_out      (state_dbg),
        .lbuffer_count_dbg_out      (count_dbg)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Called just after a falling edge; returns one falling edge later.
    task automatic push_load(input logic [31:0] a, input logic [4:0] dest, input logic [5:0] op);
        push_en = 1'b1; push_a = a; push_dest = dest; push_op = op;
        @(negedge clk);
        push_en = 1'b0;
    endtask

    task automatic wait_mem(input string tag, input logic [31:0] exp_a, input logic [2:0] exp_len);
        for (int i = 0; i < 40 && !mem_en; i++) @(negedge clk);
        check_val({tag, "_mem_en"}, 32'(mem_en), 32'd1);
        check_val({tag, "_addr"}, mem_a, exp_a);
        check_val({tag, "_len"}, 32'(mem_len), 32'(exp_len));
    endtask

    task automatic serve(input logic [31:0] data, input int hold);
        for (int i = 0; i < hold; i++) @(negedge clk);
        mem_valid = 1'b1; mem_data = data;
        @(negedge clk);
        mem_valid = 1'b0; mem_data = 32'h0;
    endtask

    task automatic expect_cdb(input string tag, input logic [4:0] dest, input logic [31:0] val);
        for (int i = 0; i < 10 && !cdb_en; i++) @(negedge clk);
        check_val({tag, "_cdb_en"}, 32'(cdb_en), 32'd1);
        check_val({tag, "_dest"}, 32'(cdb_dest), 32'(dest));
        check_val({tag, "_value"}, cdb_value, val);
        @(negedge clk);
        check_val({tag, "_cdb_pulse"}, 32'(cdb_en), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [36:0] e;
        tbl_op[0] = `LB;  tbl_data[0] = 32'h0000_007F; tbl_exp[0] = 32'h0000_007F; tbl_len[0] = 3'd1;
        tbl_op[1] = `LB;  tbl_data[1] = 32'h1234_5680; tbl_exp[1] = 32'hFFFF_FF80; tbl_len[1] = 3'd1;
        tbl_op[2] = `LH;  tbl_data[2] = 32'h0000_7FFF; tbl_exp[2] = 32'h0000_7FFF; tbl_len[2] = 3'd2;
        tbl_op[3] = `LH;  tbl_data[3] = 32'hAAAA_8000; tbl_exp[3] = 32'hFFFF_8000; tbl_len[3] = 3'd2;
        tbl_op[4] = `LW;  tbl_data[4] = 32'hDEAD_BEEF; tbl_exp[4] = 32'hDEAD_BEEF; tbl_len[4] = 3'd4;
        tbl_op[5] = `LBU; tbl_data[5] = 32'hFFFF_FFF0; tbl_exp[5] = 32'h0000_00F0; tbl_len[5] = 3'd1;
        tbl_op[6] = `LHU; tbl_data[6] = 32'h1234_F00D; tbl_exp[6] = 32'h0000_F00D; tbl_len[6] = 3'd2;
        tbl_op[7] = `LBU; tbl_data[7] = 32'h0000_0101; tbl_exp[7] = 32'h0000_0001; tbl_len[7] = 3'd1;

        rst = 1'b1; rdy = 1'b1; push_en = 1'b0; flush = 1'b0; mem_valid = 1'b0;
        push_a = '0; push_dest = '0; push_op = '0; mem_data = '0;
        @(negedge clk);
        @(negedge clk);
        check_val("rst_mem_en", 32'(mem_en), 32'd0);
        check_val("rst_cdb_en", 32'(cdb_en), 32'd0);
        check_val("rst_full", 32'(full), 32'd0);
        check_val("rst_count", 32'(count_dbg), 32'd0);
        check_val("rst_state", 32'(state_dbg), 32'd0);
        check_val("rst_mem_a", mem_a, 32'd0);
        check_val("rst_cdb_value", cdb_value, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // LB sign extension, memory answers two cycles after the request
        push_load(32'h100, 5'd3, `LB);
        check_val("t1_count", 32'(count_dbg), 32'd1);
        wait_mem("t1", 32'h100, 3'd1);
        serve(32'h0000_0080, 1);
        expect_cdb("t1", 5'd3, 32'hFFFF_FF80);

        // LHU zero extension and LW pass-through of the same data word
        push_load(32'h104, 5'd5, `LHU);
        wait_mem("t2_lhu", 32'h104, 3'd2);
        serve(32'hABCD_8001, 0);
        expect_cdb("t2_lhu", 5'd5, 32'h0000_8001);
        push_load(32'h108, 5'd6, `LW);
        wait_mem("t2_lw", 32'h108, 3'd4);
        serve(32'hABCD_8001, 0);
        expect_cdb("t2_lw", 5'd6, 32'hABCD_8001);

        // Three complete fills starting from a non-zero pointer so every fill wraps
        for (int f = 0; f < 3; f++) begin
            for (int i = 0; i < 8; i++) begin
                push_en = 1'b1;
                push_a = 32'h200 + 32'(f * 64 + i * 4);
                push_dest = 5'(f * 8 + i);
                push_op = tbl_op[i];
                exp_q.push_back({5'(f * 8 + i), tbl_exp[i]});
                @(negedge clk);
                check_val("t3_count", 32'(count_dbg), 32'(i + 1));
                if (i == 5) check_val("t3_full_at6", 32'(full), 32'd0);
                if (i == 6) check_val("t3_full_at7", 32'(full), 32'd1);
            end
            if (f == 0) begin
                push_dest = 5'd31;
                @(negedge clk);
                check_val("t3_drop_at_depth", 32'(count_dbg), 32'd8);
            end
            push_en = 1'b0;
            for (int i = 0; i < 8; i++) begin
                wait_mem("t3", 32'h200 + 32'(f * 64 + i * 4), tbl_len[i]);
                serve(tbl_data[i], i % 2);
                e = exp_q.pop_front();
                expect_cdb("t3", e[36:32], e[31:0]);
            end
            check_val("t3_empty", 32'(count_dbg), 32'd0);
        end

        // Flush with a request outstanding: drain the late reply, push during drain issues afterwards
        push_load(32'h300, 5'd7, `LW);
        wait_mem("t4_first", 32'h300, 3'd4);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check_val("t4_drain_state", 32'(state_dbg), 32'd3);
        check_val("t4_flush_mem_en", 32'(mem_en), 32'd0);
        check_val("t4_flush_count", 32'(count_dbg), 32'd0);
        push_load(32'h304, 5'd8, `LW);
        check_val("t4_drain_push_count", 32'(count_dbg), 32'd1);
        check_val("t4_drain_hold", 32'(state_dbg), 32'd3);
        check_val("t4_drain_no_issue", 32'(mem_en), 32'd0);
        serve(32'h1111_1111, 1);
        check_val("t4_idle_after_drain", 32'(state_dbg), 32'd0);
        check_val("t4_no_bcast", 32'(cdb_en), 32'd0);
        wait_mem("t4_next", 32'h304, 3'd4);
        serve(32'h1357_2468, 0);
        expect_cdb("t4_next", 5'd8, 32'h1357_2468);

        // Push and completion together at count 4, then flush together with a push
        for (int i = 0; i < 4; i++) push_load(32'h400 + 32'(i * 4), 5'(10 + i), `LW);
        check_val("t5_count4", 32'(count_dbg), 32'd4);
        mem_valid = 1'b1; mem_data = 32'h0000_00AA;
        push_en = 1'b1; push_a = 32'h410; push_dest = 5'd14; push_op = `LW;
        @(negedge clk);
        mem_valid = 1'b0; push_en = 1'b0;
        check_val("t5_count_same", 32'(count_dbg), 32'd4);
        check_val("t5_cdb_en", 32'(cdb_en), 32'd1);
        check_val("t5_cdb_dest", 32'(cdb_dest), 32'd10);
        check_val("t5_cdb_value", cdb_value, 32'h0000_00AA);
        flush = 1'b1; push_en = 1'b1; push_dest = 5'd15;
        @(negedge clk);
        flush = 1'b0; push_en = 1'b0;
        check_val("t5_flush_count", 32'(count_dbg), 32'd0);
        check_val("t5_flush_state", 32'(state_dbg), 32'd0);
        check_val("t5_flush_cdb", 32'(cdb_en), 32'd0);
        @(negedge clk);
        check_val("t5_flush_no_issue", 32'(mem_en), 32'd0);

        // Push latency into an empty queue, then rdy low freezes an outstanding request
        push_en = 1'b1; push_a = 32'h500; push_dest = 5'd20; push_op = `LH;
        #1;
`ifdef LBUFFER_BYPASS_EN
        check_val("t6_bypass_mem_en", 32'(mem_en), 32'd1);
        check_val("t6_bypass_addr", mem_a, 32'h500);
`else
        check_val("t6_no_bypass_mem_en", 32'(mem_en), 32'd0);
`endif
        @(negedge clk);
        push_en = 1'b0;
        wait_mem("t6", 32'h500, 3'd2);
        rdy = 1'b0;
        push_en = 1'b1; push_a = 32'h600; push_dest = 5'd21; push_op = `LW;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_val("t6_frz_mem_en", 32'(mem_en), 32'd1);
            check_val("t6_frz_addr", mem_a, 32'h500);
            check_val("t6_frz_count", 32'(count_dbg), 32'd1);
        end
        rdy = 1'b1; push_en = 1'b0;
        serve(32'hFFFF_7FFE, 0);
        expect_cdb("t6", 5'd20, 32'h0000_7FFE);
        check_val("t6_empty", 32'(count_dbg), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
